// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master and its port decoder.
package sd_spi_pkg;

  localparam int HALF_PER_DEFAULT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } sd_state_t;

endpackage

// File: rtl/sd_spi_master_if.sv
// Byte-transfer handshake and SPI pins between the port decoder and the SD SPI master.
interface sd_spi_master_if;
  logic       sd_start;
  logic [7:0] sd_datain;
  logic [7:0] sd_dataout;
  logic       busy;
  logic       sdclk;
  logic       sddo;
  logic       sddi;

  modport master (
    input  sd_start, sd_datain, sddi,
    output sd_dataout, busy, sdclk, sddo
  );

  modport slave (
    output sd_start, sd_datain, sddi,
    input  sd_dataout, busy, sdclk, sddo
  );
endinterface

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte shifter for an SD card; one 8-bit full-duplex transfer per sd_start.
//
// state | meaning
// IDLE  | sdclk low, sddo high, waiting for sd_start
// LOW   | sdclk low for HALF_PER cycles, current tx bit on sddo
// HIGH  | sdclk high for HALF_PER cycles, sddi sampled on the last cycle
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int HALF_PER = HALF_PER_DEFAULT
) (
  input  logic            fclk,
  input  logic            rst,
  sd_spi_master_if.master sd
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_PER - 1);

  sd_state_t  state;
  logic [7:0] half_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] rx_next;
  logic       phase_end;

  assign rx_next   = {rx_sr[6:0], sd.sddi};
  assign phase_end = (half_cnt == HALF_LAST);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      half_cnt      <= 8'd0;
      bit_cnt       <= 3'd0;
      tx_sr         <= 8'hFF;
      rx_sr         <= 8'h00;
      sd.sdclk      <= 1'b0;
      sd.sddo       <= 1'b1;
      sd.busy       <= 1'b0;
      sd.sd_dataout <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (sd.sd_start) begin
            tx_sr    <= sd.sd_datain;
            bit_cnt  <= 3'd0;
            half_cnt <= 8'd0;
            sd.sddo  <= sd.sd_datain[7];
            sd.busy  <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            half_cnt <= 8'd0;
            sd.sdclk <= 1'b1;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            half_cnt <= 8'd0;
            rx_sr    <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            sd.sdclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              // rx_next already holds the final sample in its LSB
              sd.sd_dataout <= rx_next;
              sd.busy       <= 1'b0;
              sd.sddo       <= 1'b1;
              state         <= IDLE;
            end else begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              sd.sddo <= tx_sr[6];
              state   <= LOW;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 The module SHALL have parameter HALF_PER, default 1, giving the sdclk half-period in fclk cycles (legal 1..255).
REQ-002 The module SHALL have port fclk  input  1  global FPGA clock; the single clock of the block.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port sd_start  input  1  one-fclk-cycle transfer request, already synchronised to fclk by the port decoder.
REQ-005 The module SHALL have port sd_datain  input  8  byte to transmit; 0xFF for read-initiated transfers.
REQ-006 The module SHALL have port sd_dataout  output  8  last received byte.
REQ-007 The module SHALL have port busy  output  1  transfer in progress.
REQ-008 The module SHALL have port sdclk  output  1  SPI clock to the SD card.
REQ-009 The module SHALL have port sddo  output  1  MOSI to the card.
REQ-010 The module SHALL have port sddi  input  1  MISO from the card.

Function
REQ-011 Transfers SHALL use SPI mode 0: sdclk idles low, 8 bits per transfer, MSB first.
REQ-012 The FSM SHALL have states IDLE, LOW and HIGH; reset enters IDLE.
REQ-013 In IDLE, sdclk=0, sddo=1 and busy=0.
REQ-014 On an fclk edge in IDLE with sd_start=1, the block SHALL:
- latch sd_datain into the shift register;
- clear the 3-bit bit counter and the half-period counter;
- enter LOW, with busy=1 and sddo=sd_datain[7] from the next cycle.
REQ-015 Each LOW or HIGH phase SHALL last exactly HALF_PER fclk cycles, counted by the half-period counter.
REQ-016 At the end of LOW, the FSM SHALL enter HIGH with sdclk=1; sddo SHALL NOT change.
REQ-017 On the final fclk edge of HIGH, sddi SHALL be shifted into the receive register LSB side, and the bit counter SHALL increment modulo 8.
REQ-018 At the end of HIGH, if the bit counter was below 7, the FSM SHALL:
- enter LOW with sdclk=0;
- present the next transmit bit on sddo in the same cycle.
REQ-019 At the end of HIGH on bit 7, the FSM SHALL:
- load sd_dataout with the full received byte, with the bit-7 sample in the LSB;
- return to IDLE, giving busy=0, sdclk=0 and sddo=1 on the following cycle.
REQ-020 busy SHALL be high for exactly 16*HALF_PER consecutive fclk cycles per transfer.
REQ-021 sd_dataout SHALL change only at transfer completion and hold its value indefinitely otherwise.
REQ-022 sd_start while busy=1 SHALL be ignored, with no queueing and no effect on the running transfer.
REQ-023 sd_start on the same edge that returns the FSM to IDLE SHALL be ignored; a start is accepted only while IDLE is the current state.
REQ-024 sd_datain changes during a transfer SHALL NOT affect the bits being sent.
REQ-025 sddi SHALL be sampled only at the REQ-017 edge; its value at all other times is don't-care.

Reset
REQ-026 Asserting rst SHALL immediately force, with no clock required:
- state=IDLE, sdclk=0, sddo=1, busy=0;
- sd_dataout=0xFF;
- bit and half-period counters to 0.
REQ-027 rst asserted mid-transfer SHALL abort the transfer, leave sd_dataout at 0xFF, and produce no further sdclk edges.
REQ-028 The first sd_start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 State encodings (IDLE/LOW/HIGH) and the default HALF_PER SHALL live in shared package sd_spi_pkg, which the port decoder may also reference.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 The block SHALL contain no clock-domain crossing; the toggle synchronisation of sd_start remains in the port decoder.

Verification
REQ-032 With HALF_PER=1, sd_datain=0xA5 and a card model returning 0x3C: sddo SHALL carry 1,0,1,0,0,1,0,1 at the 8 rising sdclk edges; sd_dataout SHALL be 0x3C after 16 busy cycles.
REQ-033 With HALF_PER=3, sd_datain=0xFF and sddi tied 0: sdclk high and low phases SHALL each be 3 cycles; busy SHALL last 48 cycles; sd_dataout SHALL be 0x00.
REQ-034 A second sd_start pulse 5 cycles after the first (HALF_PER=1): exactly 8 sdclk pulses, busy=16 cycles, one sd_dataout update.
REQ-035 rst asserted after 4 sdclk pulses: sdclk=0, sddo=1, busy=0 and sd_dataout=0xFF immediately; the next sd_start with 0x81 and card returning 0x7E SHALL complete with sd_dataout=0x7E.
REQ-036 Back-to-back transfers: sd_start one cycle after busy falls SHALL be accepted; sd_datain changed to 0x00 mid-transfer SHALL NOT alter the first transfer's transmitted byte 0xC3.
